// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the SRAM-like data responder. Holds the state encoding,
// the parameter defaults and the all-lanes byte-select constant.
package data_sram_responder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEFAULT_ADDR_WIDTH  = 10;
    localparam int DEFAULT_WAIT_CYCLES = 2;

    localparam logic [3:0] SEL_ALL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/sram_byte_array.sv
// Word-addressed storage with a per-lane write enable and a registered read port,
// written so that synthesis can map it onto block RAM.
module sram_byte_array
    import data_sram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [31:0]           wdata,
    input  logic                  re,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [31:0] rdata_q;

    // Storage itself is never reset so it stays mappable to block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 32'h0;
        end else if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// Memory-side responder for the core's data port: latches one request, waits a
// programmable number of cycles, performs the array access and releases the stall.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  sel,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        busy
);

    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            sel_q, sel_d;
    logic                  is_write_q, is_write_d;
    logic                  busy_q, busy_d;
    logic                  req;
    logic                  access;
    logic                  unused_addr_bits;

    assign req              = memread | memwrite;
    assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        sel_d      = sel_q;
        is_write_d = is_write_q;
        access     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d    = BUSY;
                    cnt_d      = 8'(WAIT_CYCLES);
                    idx_d      = addr[ADDR_WIDTH+1:2];
                    wdata_d    = wdata;
                    sel_d      = sel;
                    is_write_d = memwrite;
                end
            end
            BUSY: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    access  = 1'b1;
                    state_d = DONE;
                end
            end
            // The request still visible here is the one just served.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == BUSY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            idx_q      <= '0;
            wdata_q    <= 32'h0;
            sel_q      <= 4'h0;
            is_write_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            sel_q      <= sel_d;
            is_write_q <= is_write_d;
            busy_q     <= busy_d;
        end
    end

    // Gating with rst lets the pipeline resume while reset is still held.
    assign stall = ~rst & (((state_q == IDLE) & req) | (state_q == BUSY));
    assign busy  = busy_q;

    sram_byte_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .addr (idx_q),
        .we   (access & is_write_q),
        .be   (sel_q),
        .wdata(wdata_q),
        .re   (access & ~is_write_q),
        .rdata(rdata)
    );

endmodule
